push_debug_sequencer: RTL and testbench

Parametrised, synthesizable push-handshake exerciser for SPI and MIL bring-up. It replays a preloaded burst of words into any push slave (request/done), and it acknowledges and captures every word a push master delivers. Captured words are buffered for later draining. It sits between a bench or on-chip debug port and a transmitter's push buses, and adds burst buffering, inter-word gaps, delayed acknowledge and timeout detection.

---
 rtl/push_debug_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_push_debug_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/push_debug_sequencer.sv
// Push-handshake exerciser: replays a preloaded burst of words into a push slave,
// and acknowledges and buffers every word a push master delivers.
module push_debug_sequencer #(
    parameter int DATAW     = 16,
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 8,
    parameter int GAP       = 0,
    parameter int ACK_DELAY = 1,
    parameter int TIMEOUT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [DATAW-1:0] load_data,
    output logic             load_ready,
    input  logic             start,
    output logic             tx_request,
    output logic [DATAW-1:0] tx_data,
    input  logic             tx_done,
    input  logic             rx_request,
    input  logic [DATAW-1:0] rx_data,
    output logic             rx_done,
    output logic             cap_valid,
    output logic [DATAW-1:0] cap_data,
    input  logic             cap_read,
    output logic             busy,
    output logic [15:0]      tx_count,
    output logic [15:0]      rx_count,
    output logic             overflow,
    output logic             timeout
);

    localparam int TXAW = $clog2(TX_DEPTH);
    localparam int TXCW = TXAW + 1;
    localparam int RXAW = $clog2(RX_DEPTH);
    localparam int RXCW = RXAW + 1;
    localparam int GW   = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int TOW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int AW   = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_GAP} tx_state_e;

    // ---------------- playback FIFO ----------------
    logic [DATAW-1:0] tx_mem [TX_DEPTH];
    logic [TXAW-1:0]  tx_rd_q, tx_wr_q;
    logic [TXCW-1:0]  tx_cnt_q, tx_cnt_d;
    logic             tx_push, tx_pop;

    tx_state_e        state_q;
    logic             tx_request_q;
    logic [TOW-1:0]   wait_cnt_q;
    logic [GW-1:0]    gap_cnt_q;
    logic [15:0]      tx_count_q;
    logic             timeout_q;
    logic             wait_expire, gap_done;

    assign load_ready  = (tx_cnt_q != TXCW'(TX_DEPTH));
    assign tx_push     = load_valid && load_ready;
    assign wait_expire = (TIMEOUT != 0) && (wait_cnt_q == TOW'(TIMEOUT - 1));
    // A done arriving on the expiry cycle wins, so it is counted rather than timed out.
    assign tx_pop      = (state_q == S_WAIT) && (tx_done || wait_expire);
    assign tx_cnt_d    = tx_cnt_q + TXCW'(tx_push) - TXCW'(tx_pop);
    assign gap_done    = (gap_cnt_q == GW'(GAP - 1));

    // NOTE: storage arrays carry no reset; the pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_rd_q  <= '0;
            tx_wr_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + TXAW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + TXAW'(1);
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // ---------------- playback FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            tx_request_q <= 1'b0;
            wait_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            tx_count_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            tx_request_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && (tx_cnt_q != '0)) begin
                        state_q      <= S_REQ;
                        tx_request_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    state_q    <= S_WAIT;
                    wait_cnt_q <= '0;
                end
                S_WAIT: begin
                    if (tx_pop) begin
                        if (tx_done) tx_count_q <= tx_count_q + 16'd1;
                        else         timeout_q  <= 1'b1;
                        if (GAP > 0) begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= '0;
                        end else if (tx_cnt_d != '0) begin
                            state_q      <= S_REQ;
                            tx_request_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TOW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_done) begin
                        if (tx_cnt_d != '0) begin
                            state_q      <= S_REQ;
                            tx_request_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_request = tx_request_q;
    assign tx_data    = (state_q == S_REQ || state_q == S_WAIT) ? tx_mem[tx_rd_q] : '0;
    assign busy       = (state_q != S_IDLE);
    assign tx_count   = tx_count_q;
    assign timeout    = timeout_q;

    // ---------------- capture side ----------------
    logic [DATAW-1:0] rx_mem [RX_DEPTH];
    logic [RXAW-1:0]  cap_rd_q, cap_wr_q;
    logic [RXCW-1:0]  cap_cnt_q;
    logic [AW-1:0]    ack_cnt_q;
    logic             rx_done_q, overflow_q;
    logic [15:0]      rx_count_q;
    logic             rx_pending, rx_accept, cap_pop, cap_push, cap_full;

    // The master is locked out until the cycle after its acknowledge.
    assign rx_pending = rx_done_q || (ack_cnt_q != '0);
    assign rx_accept  = rx_request && !rx_pending;
    assign cap_full   = (cap_cnt_q == RXCW'(RX_DEPTH));
    assign cap_pop    = cap_read && (cap_cnt_q != '0);
    assign cap_push   = rx_accept && (!cap_full || cap_pop);

    always_ff @(posedge clk) begin
        if (cap_push) rx_mem[cap_wr_q] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cap_rd_q   <= '0;
            cap_wr_q   <= '0;
            cap_cnt_q  <= '0;
            ack_cnt_q  <= '0;
            rx_done_q  <= 1'b0;
            rx_count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            if (cap_push) cap_wr_q <= cap_wr_q + RXAW'(1);
            if (cap_pop)  cap_rd_q <= cap_rd_q + RXAW'(1);
            cap_cnt_q <= cap_cnt_q + RXCW'(cap_push) - RXCW'(cap_pop);

            if (rx_accept) begin
                ack_cnt_q <= AW'(ACK_DELAY - 1);
                if (!cap_push) overflow_q <= 1'b1;
                if (ACK_DELAY == 1) begin
                    rx_done_q  <= 1'b1;
                    rx_count_q <= rx_count_q + 16'd1;
                end
            end else if (ack_cnt_q != '0) begin
                ack_cnt_q <= ack_cnt_q - AW'(1);
                if (ack_cnt_q == AW'(1)) begin
                    rx_done_q  <= 1'b1;
                    rx_count_q <= rx_count_q + 16'd1;
                end
            end
        end
    end

    assign rx_done   = rx_done_q;
    assign cap_valid = (cap_cnt_q != '0);
    assign cap_data  = cap_valid ? rx_mem[cap_rd_q] : '0;
    assign rx_count  = rx_count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_push_debug_sequencer.sv
// Randomized bench for push_debug_sequencer against a queue-and-timestamp reference model.
module tb_push_debug_sequencer;

    localparam int DATAW     = 16;
    localparam int TX_DEPTH  = 4;
    localparam int RX_DEPTH  = 4;
    localparam int GAP       = 2;
    localparam int ACK_DELAY = 3;
    localparam int TIMEOUT   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load_valid = 1'b0;
    logic [DATAW-1:0] load_data = '0;
    logic             load_ready;
    logic             start = 1'b0;
    logic             tx_request;
    logic [DATAW-1:0] tx_data;
    logic             tx_done = 1'b0;
    logic             rx_request = 1'b0;
    logic [DATAW-1:0] rx_data = '0;
    logic             rx_done;
    logic             cap_valid;
    logic [DATAW-1:0] cap_data;
    logic             cap_read = 1'b0;
    logic             busy;
    logic [15:0]      tx_count, rx_count;
    logic             overflow, timeout;

    always #5 clk = ~clk;

    push_debug_sequencer #(
        .DATAW(DATAW), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH),
        .GAP(GAP), .ACK_DELAY(ACK_DELAY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .start(start), .tx_request(tx_request), .tx_data(tx_data), .tx_done(tx_done),
        .rx_request(rx_request), .rx_data(rx_data), .rx_done(rx_done),
        .cap_valid(cap_valid), .cap_data(cap_data), .cap_read(cap_read),
        .busy(busy), .tx_count(tx_count), .rx_count(rx_count),
        .overflow(overflow), .timeout(timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words are queues, timing is kept as edge timestamps.
    logic [DATAW-1:0] txq[$];
    logic [DATAW-1:0] capq[$];
    int   c = 0;             // edge index
    bit   m_busy, m_wait;    // burst running / a word is outstanding at the slave
    int   m_req;             // edge at which the outstanding request was issued
    int   m_dec;             // edge at which the next word is decided after a done/timeout
    int   m_done_edge, m_rx_free;
    logic [15:0] m_txcnt, m_rxcnt;
    bit   m_ovf, m_to, e_req, e_done;

    task automatic model_reset();
        txq.delete();
        capq.delete();
        m_busy = 0; m_wait = 0; m_req = -10; m_dec = -1;
        m_done_edge = -1; m_rx_free = 0;
        m_txcnt = '0; m_rxcnt = '0; m_ovf = 0; m_to = 0;
        e_req = 0; e_done = 0;
    endtask

    task automatic model_step();
        int  s0;
        bit  do_pop, do_load, cpop;
        if (!rst) begin
            model_reset();
            return;
        end
        s0 = txq.size();
        do_pop = 0;
        e_req = 0;
        e_done = 0;
        do_load = load_valid && (s0 < TX_DEPTH);
        if (!m_busy) begin
            if (start && s0 > 0) begin
                m_busy = 1; m_wait = 1; m_req = c; e_req = 1;
            end
        end else if (m_wait && c >= m_req + 2) begin
            if (tx_done) begin
                do_pop = 1;
                m_txcnt++;
            end else if (c == m_req + 1 + TIMEOUT) begin
                do_pop = 1;
                m_to = 1;
            end
            if (do_pop) begin
                m_wait = 0;
                m_dec = c + GAP;
            end
        end
        if (do_pop) void'(txq.pop_front());
        if (do_load) txq.push_back(load_data);
        if (m_busy && !m_wait && m_dec == c) begin
            if (txq.size() > 0) begin
                m_wait = 1; m_req = c; e_req = 1;
            end else begin
                m_busy = 0;
            end
        end

        cpop = cap_read && (capq.size() > 0);
        if (cpop) void'(capq.pop_front());
        if (rx_request && c >= m_rx_free) begin
            m_done_edge = c + ACK_DELAY - 1;
            m_rx_free   = m_done_edge + 2;
            if (capq.size() < RX_DEPTH) capq.push_back(rx_data);
            else m_ovf = 1;
        end
        if (c == m_done_edge) begin
            e_done = 1;
            m_rxcnt++;
        end
    endtask

    task automatic compare_outputs();
        check("tx_request", tx_request, e_req);
        check("busy", busy, m_busy);
        check("load_ready", load_ready, txq.size() < TX_DEPTH);
        if (m_wait) check("tx_data", tx_data, txq[0]);
        check("rx_done", rx_done, e_done);
        check("cap_valid", cap_valid, capq.size() > 0);
        if (capq.size() > 0) check("cap_data", cap_data, capq[0]);
        check("tx_count", tx_count, m_txcnt);
        check("rx_count", rx_count, m_rxcnt);
        check("overflow", overflow, m_ovf);
        check("timeout", timeout, m_to);
    endtask

    function automatic bit chance(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    task automatic cycle(input bit r, input int p_start, input int p_load, input int p_done,
                         input int p_rx, input int p_read);
        @(negedge clk);
        rst        = r;
        start      = chance(p_start);
        load_valid = chance(p_load);
        load_data  = DATAW'($urandom);
        tx_done    = chance(p_done);
        rx_request = chance(p_rx);
        rx_data    = DATAW'($urandom);
        cap_read   = chance(p_read);
        @(posedge clk);
        c++;
        model_step();
        #1;
        compare_outputs();
    endtask

    initial begin
        bit found;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 50, 50, 50, 50, 50);
        check("rst_tx_data", tx_data, '0);
        check("rst_cap_data", cap_data, '0);

        // normal traffic, overflow pressure, timeout pressure, mixed
        for (int i = 0; i < 500; i++) cycle(1'b1, 10, 40, 40, 40, 50);
        for (int i = 0; i < 400; i++) cycle(1'b1, 10, 30, 40, 70, 5);
        for (int i = 0; i < 500; i++) cycle(1'b1, 15, 40, 4, 30, 40);

        // reset while a word is outstanding with at least two queued
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            cycle(1'b1, 20, 60, 10, 30, 30);
            found = m_busy && m_wait && (txq.size() >= 2);
        end
        check("mid_reset_setup", found, 1'b1);
        cycle(1'b0, 50, 50, 50, 50, 50);
        cycle(1'b0, 50, 50, 50, 50, 50);
        check("mid_rst_tx_data", tx_data, '0);
        check("mid_rst_cap_data", cap_data, '0);
        // loads but no start: nothing may be requested
        for (int i = 0; i < 20; i++) cycle(1'b1, 0, 50, 50, 20, 20);

        for (int i = 0; i < 500; i++) cycle(1'b1, 10, 35, 25, 40, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
